serial_add_ctrl: RTL

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl_pkg.sv | 12 +
 rtl/full_adder_1bit.sv | 20 ++
 rtl/serial_add_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_ctrl_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder_1bit.sv
// Gate-level 1-bit full adder cell.
module full_adder_1bit (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  logic ab_x;
  logic ab_a;
  logic cx_a;

  xor g_x0 (ab_x, A, B);
  xor g_x1 (S, ab_x, Cin);
  and g_a0 (ab_a, A, B);
  and g_a1 (cx_a, ab_x, Cin);
  or  g_o0 (Cout, ab_a, cx_a);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: accepts two operands, adds one bit per cycle LSB first,
// and holds the registered result until the consumer takes it.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  state_t             state;
  state_t             state_d;
  logic               accept_c;
  logic               shift_c;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic               fa_s;
  logic               fa_co;

  full_adder_1bit u_fa (
    .A    (a_reg[0]),
    .B    (b_reg[0]),
    .Cin  (carry),
    .S    (fa_s),
    .Cout (fa_co)
  );

  // State register plus registered handshake/status flags decoded from next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      busy      <= (state_d != IDLE);
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state;
    accept_c = 1'b0;
    shift_c  = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept_c = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        shift_c = 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand shifters, carry flop, bit counter and result shifter (sum enters at MSB).
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
    end else if (accept_c) begin
      a_reg <= a;
      b_reg <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (shift_c) begin
      a_reg <= a_reg >> 1;
      b_reg <= b_reg >> 1;
      sum   <= {fa_s, sum[WIDTH-1:1]};
      carry <= fa_co;
      cnt   <= cnt + CNT_W'(1);
    end
  end

  assign cout = carry;

endmodule
